// File: rtl/filter_out_capture.sv
// rtl/filter_out_capture.sv - Captures filter output once per sample period into a FIFO read port
//
// Purpose: counts clk30x cycles, strobes every DEC cycles while a frame runs,
// sign-extends yout to 32 bits and pushes it into a DEPTH-entry circular FIFO.
// After N captures the block drains the FIFO and reports done.
// Optional feature macro: FILTER_SKIP_EN (drop the first SKIP strobes of each frame).
//
// Ports:
//   clk30x     in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, starts a frame from IDLE or DONE
//   yout       in   16-bit two's complement filter output
//   rd_valid   out  FIFO head valid
//   rd_data    out  FIFO head, sign-extended yout
//   rd_ready   in   consumer accepts head
//   busy       out  frame running or draining
//   done       out  frame complete
//   overflow   out  sticky, a capture was dropped on a full FIFO
//   sample_cnt out  captures counted this frame (0..N)

module filter_out_capture #(
    parameter int DEC   = 30,
    parameter int N     = 4096,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int SKIP  = 2,
    localparam int CW   = $clog2(N) + 1,
    localparam int PW   = (DEC > 1) ? $clog2(DEC) : 1
) (
    input  logic          clk30x,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   yout,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [CW-1:0] sample_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic strobe, push_req, pop, full, push_ok, drop, start_ok;

    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    assign strobe   = (state == S_RUN) && (phase == PW'(DEC - 1));

`ifdef FILTER_SKIP_EN
    localparam int SW = $clog2(SKIP + 1) + 1;
    logic [SW-1:0] skip_cnt;
    logic          skipping;

    // Leading strobes of a frame only advance the skip counter.
    assign skipping = (skip_cnt < SW'(SKIP));
    assign push_req = strobe && !skipping;

    always_ff @(posedge clk30x or negedge rst_n) begin
        if (!rst_n)
            skip_cnt <= '0;
        else if (start_ok)
            skip_cnt <= '0;
        else if (strobe && skipping)
            skip_cnt <= skip_cnt + SW'(1);
    end
`else
    assign push_req = strobe;
`endif

    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 32'h0;
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (push_req && sample_cnt == CW'(N - 1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (count == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk30x or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                phase      <= '0;
                sample_cnt <= '0;
                overflow   <= 1'b0;
            end else begin
                if (state == S_RUN)
                    phase <= strobe ? '0 : phase + PW'(1);
                // Dropped samples still count so the frame length stays N.
                if (push_req)
                    sample_cnt <= sample_cnt + CW'(1);
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk30x or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk30x) begin
        if (push_ok)
            mem[wr_ptr] <= {{16{yout[15]}}, yout};
    end

endmodule

// File: doc/filter_out_capture.md
Name: filter_out_capture

Overview:
- Output-side counterpart to the filter sample feeder: captures filter output `yout` once per sample period.
- Sign-extends each captured sample to 32 bits and buffers it in a FIFO.
- Presents the buffered samples on a valid/ready read port to the result logger or host.
- Sits downstream of `filter_ideal` in the system wrapper and counts a frame of N samples, then signals done.

Parameters:
- DEC, 30, clk30x cycles per sample period; capture strobe fires once per DEC cycles.
- N, 4096, samples per frame.
- DEPTH, 16, FIFO entries (power of two).
- AW, 4, log2(DEPTH).
- SKIP, 2, leading samples discarded; used only with FILTER_SKIP_EN.

Ports:
- clk30x  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame from IDLE or DONE.
- yout  in  16  filter output, two's complement.
- rd_valid  out  1  FIFO head valid.
- rd_data  out  32  FIFO head, sign-extended yout.
- rd_ready  in  1  consumer accepts head.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky: a capture was dropped because the FIFO was full.
- sample_cnt  out  13  captures taken this frame (0..N); width = clog2(N)+1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; phase=0; sample_cnt=0.
  - FIFO empty; rd_valid=0, rd_data=0.
  - busy=0, done=0, overflow=0.
- States IDLE, RUN, DRAIN, DONE:
  - IDLE: start -> RUN. Clears phase, sample_cnt and overflow.
  - RUN: phase increments each cycle.
    - At phase==DEC-1: strobe; phase->0; yout captured; sample_cnt+1.
    - When the strobe makes sample_cnt==N: -> DRAIN.
    - start ignored.
  - DRAIN: no captures; -> DONE on the cycle the FIFO is empty. start ignored.
  - DONE: done=1. start -> RUN with the same clears as IDLE. FIFO contents are already empty.
- Capture timing:
  - First strobe is DEC cycles after the start cycle, i.e. yout is sampled on the DEC-th rising edge after start.
  - Push data = {{16{yout[15]}}, yout}. Example: 16'h8001 -> 32'hFFFF8001; 16'h7FFF -> 32'h00007FFF.
- FIFO:
  - Circular buffer with write and read pointers of AW bits that wrap modulo DEPTH; count is AW+1 bits.
  - rd_data/rd_valid reflect the head combinationally from registered storage.
  - Pop occurs when rd_valid && rd_ready.
  - Push while full:
    - With a pop the same cycle: accepted; count unchanged.
    - Without a pop: sample dropped, overflow set (sticky), sample_cnt still increments so frame length stays N.
  - Pop when empty: no effect.
  - Push and pop when empty: push lands; rd_valid asserts next cycle.
- Reset mid-frame: everything returns to the reset values immediately; buffered data is lost.

Optional Feature:
- Macro: FILTER_SKIP_EN.
- Defined:
  - The first SKIP strobes of each frame are not pushed, which discards filter pipeline fill.
  - sample_cnt counts only pushed samples; the frame ends after N pushed samples, i.e. N+SKIP strobes.
- Undefined: every strobe pushes; SKIP is unused.

Test Plan:
- Basic capture: DEC=30, N=4, FIFO drained continuously; yout held at 16'h0005 -> four rd_data=32'h00000005; done rises after the 4th strobe plus drain; sample_cnt=4; overflow=0.
- Sign extension: yout=16'hFFFE, then 16'h8000 -> rd_data 32'hFFFFFFFE, then 32'hFFFF8000.
- Overflow: DEPTH=16, N=20, rd_ready=0 -> 16 entries held, overflow=1 after the 17th strobe; then rd_ready=1 -> exactly 16 pops in order; done after empty.
- Full with simultaneous pop: FIFO full, rd_ready=1 on a strobe cycle -> push accepted, count stays 16, overflow stays 0.
- Reset mid-frame: rst_n low at sample 100 of N=4096 -> rd_valid=0, busy=0, sample_cnt=0 the same cycle; a new start then captures from the 0th count again.
- FILTER_SKIP_EN, SKIP=2, N=3; yout changes per period 1,2,3,4,5 -> rd_data 3,4,5; done after the 5th strobe plus drain.
